// File: rtl/rot_pkg.sv
// Shared types and constants for the rotary encoder controller.
package rot_pkg;

    localparam int POS_W    = 8;
    localparam int DB_CNT_W = 16;

    typedef logic [POS_W-1:0] pos_t;

    localparam logic [1:0] AB_00 = 2'b00;
    localparam logic [1:0] AB_01 = 2'b01;
    localparam logic [1:0] AB_10 = 2'b10;
    localparam logic [1:0] AB_11 = 2'b11;

    typedef enum logic [2:0] {
        ST_REST,
        ST_CW1,
        ST_CW2,
        ST_CW3,
        ST_CCW1,
        ST_CCW2,
        ST_CCW3
    } rot_state_e;

    function automatic pos_t pos_clamp(
        input pos_t v,
        input pos_t lo,
        input pos_t hi
    );
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/rot_debounce.sv
// Two-flop synchronizer followed by a stable-count debounce filter.
module rot_debounce
    import rot_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic filt_o
);

    localparam logic [DB_CNT_W-1:0] LAST = DB_CNT_W'(DB_CYCLES - 1);

    logic                s1_q;
    logic                s2_q;
    logic                filt_q;
    logic                filt_d;
    logic [DB_CNT_W-1:0] cnt_q;
    logic [DB_CNT_W-1:0] cnt_d;

    // Any cycle where the synced value matches the filter restarts the count.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (s2_q != filt_q) begin
            if (cnt_q == LAST) begin
                filt_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= raw_i;
            s2_q   <= s1_q;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/rotary_encoder_ctrl.sv
// Quadrature rotary encoder decoder with debounced inputs and position counter.
// Optional macro ROT_ERR_CNT_EN adds a saturating err_cnt output.
module rotary_encoder_ctrl
    import rot_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1000,
    parameter int          POS_MIN   = 0,
    parameter int          POS_MAX   = 255,
    parameter int          WRAP      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw,
    input  logic             dt,
    input  logic             ld,
    input  logic [POS_W-1:0] ld_val,
    output logic [POS_W-1:0] pos,
    output logic             step_cw,
    output logic             step_ccw,
    output logic             err
`ifdef ROT_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    localparam pos_t PMIN = pos_t'(POS_MIN);
    localparam pos_t PMAX = pos_t'(POS_MAX);

    logic       fa;
    logic       fb;
    logic [1:0] ab;
    logic [1:0] chg;

    rot_state_e state_q, state_d;
    logic [1:0] ab_q;
    pos_t       pos_q, pos_d;
    logic       cw_q, cw_d;
    logic       ccw_q, ccw_d;
    logic       err_q, err_d;

    rot_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_a (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (sw),
        .filt_o (fa)
    );

    rot_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_b (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (dt),
        .filt_o (fb)
    );

    assign ab  = {fa, fb};
    assign chg = ab ^ ab_q;

    // A two-bit change is judged against the previous filtered pair,
    // so a held illegal code reports only once.
    always_comb begin
        state_d = state_q;
        cw_d    = 1'b0;
        ccw_d   = 1'b0;
        err_d   = 1'b0;
        if (chg == AB_11) begin
            err_d = 1'b1;
            if (ab == AB_00) state_d = ST_REST;
        end else if (chg != AB_00) begin
            unique case (state_q)
                ST_REST: begin
                    if (ab == AB_10)      state_d = ST_CW1;
                    else if (ab == AB_01) state_d = ST_CCW1;
                end
                ST_CW1: begin
                    if (ab == AB_11)      state_d = ST_CW2;
                    else if (ab == AB_00) state_d = ST_REST;
                end
                ST_CW2: begin
                    if (ab == AB_01)      state_d = ST_CW3;
                    else if (ab == AB_10) state_d = ST_CW1;
                end
                ST_CW3: begin
                    if (ab == AB_00) begin
                        state_d = ST_REST;
                        cw_d    = 1'b1;
                    end else if (ab == AB_11) begin
                        state_d = ST_CW2;
                    end
                end
                ST_CCW1: begin
                    if (ab == AB_11)      state_d = ST_CCW2;
                    else if (ab == AB_00) state_d = ST_REST;
                end
                ST_CCW2: begin
                    if (ab == AB_10)      state_d = ST_CCW3;
                    else if (ab == AB_01) state_d = ST_CCW1;
                end
                ST_CCW3: begin
                    if (ab == AB_00) begin
                        state_d = ST_REST;
                        ccw_d   = 1'b1;
                    end else if (ab == AB_11) begin
                        state_d = ST_CCW2;
                    end
                end
                default: state_d = ST_REST;
            endcase
        end
    end

    always_comb begin
        pos_d = pos_q;
        if (ld) begin
            pos_d = pos_clamp(ld_val, PMIN, PMAX);
        end else if (cw_d) begin
            if (pos_q >= PMAX) pos_d = (WRAP != 0) ? PMIN : PMAX;
            else               pos_d = pos_q + 1'b1;
        end else if (ccw_d) begin
            if (pos_q <= PMIN) pos_d = (WRAP != 0) ? PMAX : PMIN;
            else               pos_d = pos_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_REST;
            ab_q    <= AB_00;
            pos_q   <= PMIN;
            cw_q    <= 1'b0;
            ccw_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ab_q    <= ab;
            pos_q   <= pos_d;
            cw_q    <= cw_d;
            ccw_q   <= ccw_d;
            err_q   <= err_d;
        end
    end

    assign pos      = pos_q;
    assign step_cw  = cw_q;
    assign step_ccw = ccw_q;
    assign err      = err_q;

`ifdef ROT_ERR_CNT_EN
    logic [7:0] ecnt_q, ecnt_d;

    always_comb begin
        ecnt_d = ecnt_q;
        if (ld)                             ecnt_d = '0;
        else if (err_d && ecnt_q != 8'hFF)  ecnt_d = ecnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ecnt_q <= '0;
        else     ecnt_q <= ecnt_d;
    end

    assign err_cnt = ecnt_q;
`endif

endmodule
